// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: three-state sequencer between an instruction source and a combinational ALU.
// Define CU_RETIRE_CNT_EN to add the retire_cnt output and its counter.
module alu_ctrl_unit #(
    parameter int NREGS = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic [5:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_cout,
    input  logic          alu_z,
    input  logic          alu_n,
    output logic          done,
    output logic          err,
    output logic [2:0]    flags,
`ifdef CU_RETIRE_CNT_EN
    output logic [31:0]   retire_cnt,
`endif
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_SUB = 6'b010001;
    localparam logic [5:0] OP_EQ  = 6'b100000;
    localparam logic [5:0] OP_NE  = 6'b100001;
    localparam logic [5:0] OP_LE  = 6'b100010;
    localparam logic [5:0] OP_GT  = 6'b100011;
    localparam logic [5:0] OP_SLL = 6'b110000;
    localparam logic [5:0] OP_SRL = 6'b110001;
    localparam logic [5:0] OP_SRA = 6'b110010;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t        state;
    state_t        state_d;

    logic [DW-1:0] rf [NREGS];
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd_q;
    logic [DW-1:0] res_q;
    logic          cout_q;
    logic          z_q;
    logic          n_q;
    logic          legal_q;
    logic          legal;
    logic          is_addsub;
    logic          accept;
    logic          wb_en;
    logic          unused_bits;

    assign rd  = instr[21 +: RW];
    assign rs1 = instr[16 +: RW];
    assign rs2 = instr[11 +: RW];

    // Index bits above RW and the low instruction field carry no meaning here.
    assign unused_bits = ^{instr[25:0], dbg_addr};

    // alu_op is held from issue through writeback, so it doubles as the decoded opcode.
    always_comb begin
        legal     = 1'b0;
        is_addsub = 1'b0;
        unique case (alu_op)
            OP_ADD, OP_SUB: begin
                legal     = 1'b1;
                is_addsub = 1'b1;
            end
            OP_EQ, OP_NE, OP_LE, OP_GT,
            OP_SLL, OP_SRL, OP_SRA: begin
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                done    = 1'b1;
                err     = ~legal_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept  = instr_valid & instr_ready;
    assign wb_en   = (state == WB) & legal_q;
    assign alu_cin = flags[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            legal_q <= 1'b0;
            flags   <= 3'b000;
        end else begin
            if (accept) begin
                alu_op <= instr[31:26];
                alu_a  <= rf[rs1];
                alu_b  <= rf[rs2];
                rd_q   <= rd;
            end
            if (state == EXEC) begin
                res_q   <= alu_res;
                cout_q  <= alu_cout;
                z_q     <= alu_z;
                n_q     <= alu_n;
                legal_q <= legal;
            end
            if (wb_en) begin
                flags[1] <= z_q;
                flags[0] <= n_q;
                if (is_addsub) begin
                    flags[2] <= cout_q;
                end
            end
        end
    end

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && (rd_q != '0)) begin
            rf[rd_q] <= res_q;
        end
    end

    assign dbg_data = rf[dbg_addr[RW-1:0]];

`ifdef CU_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (state == WB) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit: random and directed instructions against a register-file model,
// with a stub ALU and a queue-based monitor that checks every retirement.
module tb_alu_ctrl_unit;
    localparam logic [5:0] ADD = 6'b010000;
    localparam logic [5:0] SUB = 6'b010001;
    localparam logic [5:0] EQ  = 6'b100000;
    localparam logic [5:0] NE  = 6'b100001;
    localparam logic [5:0] LE  = 6'b100010;
    localparam logic [5:0] GT  = 6'b100011;
    localparam logic [5:0] SLL = 6'b110000;
    localparam logic [5:0] SRL = 6'b110001;
    localparam logic [5:0] SRA = 6'b110010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [5:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic [31:0] alu_res;
    logic        alu_cout;
    logic        alu_z;
    logic        alu_n;
    logic        done;
    logic        err;
    logic [2:0]  flags;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
`ifdef CU_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_busy = 1'b0;
    bit ld_en = 1'b0;
    logic [31:0] ld_val = '0;
    logic [32:0] stub_r;

    typedef struct {
        logic [5:0]  op;
        int          rd;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        err;
        logic [31:0] val;
        logic [2:0]  flg;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mrf[32];
    logic        mc = 1'b0;
    logic        mz = 1'b0;
    logic        mn = 1'b0;
    int          mret = 0;
    logic [5:0]  ops[9] = '{ADD, SUB, EQ, NE, LE, GT, SLL, SRL, SRA};

    alu_ctrl_unit #(.NREGS(32), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .done       (done),
        .err        (err),
        .flags      (flags),
`ifdef CU_RETIRE_CNT_EN
        .retire_cnt (retire_cnt),
`endif
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {ADD, SUB, EQ, NE, LE, GT, SLL, SRL, SRA};
    endfunction

    // {carry/borrow, result}; illegal opcodes give deliberate junk
    function automatic logic [32:0] ref_alu(input logic [5:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] r;
        case (op)
            ADD:     r = {1'b0, a} + {1'b0, b};
            SUB:     r = {a < b, a - b};
            EQ:      r = {1'b0, 32'(a == b)};
            NE:      r = {1'b0, 32'(a != b)};
            LE:      r = {1'b0, 32'($signed(a) <= $signed(b))};
            GT:      r = {1'b0, 32'($signed(a) > $signed(b))};
            SLL:     r = {1'b0, a << b[4:0]};
            SRL:     r = {1'b0, a >> b[4:0]};
            SRA:     r = {1'b0, 32'($signed(a) >>> b[4:0])};
            default: r = {1'b1, a ^ 32'hA5A5_5A5A};
        endcase
        return r;
    endfunction

    always_comb begin
        stub_r = ref_alu(alu_op, alu_a, alu_b);
        if (ld_en && alu_op == ADD) stub_r = {1'b0, ld_val};
        alu_res  = stub_r[31:0];
        alu_cout = stub_r[32];
        alu_z    = (stub_r[31:0] == 32'd0);
        alu_n    = stub_r[31];
        if (!legal_op(alu_op)) begin
            alu_z = 1'b1;
            alu_n = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        mc = 1'b0;
        mz = 1'b0;
        mn = 1'b0;
        mret = 0;
    endtask

    task automatic model_issue(input logic [5:0] op, input int rd, input int rs1, input int rs2,
                               input bit load, input logic [31:0] lv, input int acc);
        exp_t e;
        logic [32:0] r;
        e.op  = op;
        e.rd  = rd;
        e.a   = mrf[rs1];
        e.b   = mrf[rs2];
        e.cin = mc;
        e.err = !legal_op(op);
        e.acc = acc;
        if (legal_op(op)) begin
            r = load ? {1'b0, lv} : ref_alu(op, e.a, e.b);
            mz = (r[31:0] == 32'd0);
            mn = r[31];
            if (op == ADD || op == SUB) mc = r[32];
            if (rd != 0) mrf[rd] = r[31:0];
        end
        e.val = mrf[rd];
        e.flg = {mc, mz, mn};
        mret++;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [5:0] op, input int rd, input int rs1, input int rs2,
                         input bit load, input logic [31:0] lv, input bit hold);
        int w = 0;
        @(negedge clk);
        instr = {op, 5'(rd), 5'(rs1), 5'(rs2), 11'($urandom)};
        instr_valid = 1'b1;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            chk("handshake_timeout", 64'(instr_ready), 64'd1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ld_en  = load;
        ld_val = lv;
        model_issue(op, rd, rs1, rs2, load, lv, cyc);
        if (hold) begin
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || mon_busy) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 64'(exp_q.size() == 0 && !mon_busy), 64'd1);
    endtask

    // monitor: reset sweep, then one full check per retirement
    initial begin
        exp_t e;
        #3;
        chk("rst_ready", 64'(instr_ready), 64'd1);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("rst_dbg_r%0d", i), 64'(dbg_data), 64'd0);
        end
        forever begin
            @(negedge clk);
            if (rst_n && err && !done) chk("err_without_done", 64'(err), 64'd0);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_busy = 1'b1;
                    e = exp_q.pop_front();
                    chk("latency", 64'(cyc), 64'(e.acc + 1));
                    chk("err", 64'(err), 64'(e.err));
                    chk("alu_op", 64'(alu_op), 64'(e.op));
                    chk("alu_a", 64'(alu_a), 64'(e.a));
                    chk("alu_b", 64'(alu_b), 64'(e.b));
                    chk("alu_cin", 64'(alu_cin), 64'(e.cin));
                    chk("busy_ready", 64'(instr_ready), 64'd0);
                    @(posedge clk);
                    #1;
                    dbg_addr = 5'(e.rd);
                    #1;
                    chk($sformatf("rf_r%0d", e.rd), 64'(dbg_data), 64'(e.val));
                    chk("flags", 64'(flags), 64'(e.flg));
                    chk("ready_after", 64'(instr_ready), 64'd1);
                    chk("done_single", 64'(done), 64'd0);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        int p;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b1;

        issue(ADD, 1, 0, 0, 1, 32'd5, 0);
        issue(ADD, 2, 0, 0, 1, 32'd3, 0);
        issue(ADD, 3, 1, 2, 0, 0, 0);
        issue(SUB, 4, 2, 1, 0, 0, 0);
        issue(EQ, 5, 1, 1, 0, 0, 0);
        issue(6'b111111, 5, 1, 2, 0, 0, 0);
        issue(ADD, 0, 1, 1, 0, 0, 1);
        drain();

        for (int n = 0; n < 200; n++) begin
            p = $urandom_range(0, 9);
            if (p < 2) begin
                issue(ADD, $urandom_range(0, 31), 0, 0, 1, $urandom, 0);
            end else if (p == 2) begin
                do op = 6'($urandom); while (legal_op(op));
                issue(op, $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), 0, 0, $urandom_range(0, 1) == 1);
            end else begin
                issue(ops[$urandom_range(0, 8)], $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 31), 0, 0,
                      $urandom_range(0, 3) == 0);
            end
        end
        drain();

        issue(ADD, 6, 1, 2, 0, 0, 0);
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        ld_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_flags", 64'(flags), 64'd0);
        chk("midrst_ready", 64'(instr_ready), 64'd1);
`ifdef CU_RETIRE_CNT_EN
        chk("retire_cnt_rst", 64'(retire_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(ADD, 7, 6, 6, 0, 0, 0);
        issue(SUB, 8, 6, 1, 0, 0, 0);
        drain();
`ifdef CU_RETIRE_CNT_EN
        chk("retire_cnt_two", 64'(retire_cnt), 64'(mret));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
